// File: rtl/bram_pkg.sv
// -----------------------------------------------------------------------------
// bram_pkg
// Shared definitions for the simple dual-port block RAM and its clear sequencer:
//   - read-during-write mode constants
//   - clear-sequencer state encoding
//   - byte_lanes(): number of 8-bit lanes in a data word
//   - merge_bytes(): per-lane merge of new data over an old word under a mask
// merge_bytes works on a fixed maximum width; callers widen their operands with
// a cast and truncate the result back to their own word width.
// -----------------------------------------------------------------------------
package bram_pkg;

    localparam int unsigned RDW_READ_FIRST  = 0;
    localparam int unsigned RDW_WRITE_FIRST = 1;

    localparam int unsigned MAX_DATA_WIDTH = 256;
    localparam int unsigned MAX_LANES      = MAX_DATA_WIDTH / 8;

    typedef enum logic {
        INIT_IDLE  = 1'b0,
        INIT_CLEAR = 1'b1
    } init_state_e;

    function automatic int unsigned byte_lanes(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic logic [MAX_DATA_WIDTH-1:0] merge_bytes(
        input logic [MAX_DATA_WIDTH-1:0] old_word,
        input logic [MAX_DATA_WIDTH-1:0] new_word,
        input logic [MAX_LANES-1:0]      mask
    );
        logic [MAX_DATA_WIDTH-1:0] result;
        result = old_word;
        for (int unsigned k = 0; k < MAX_LANES; k++) begin
            if (mask[k]) begin
                result[8*k +: 8] = new_word[8*k +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bram_init_sequencer.sv
// -----------------------------------------------------------------------------
// bram_init_sequencer
// After reset, walks an address counter across the whole array and requests a
// zero write at each address, one word per cycle. Reset held high parks the
// counter at 0; reset asserted mid-clear restarts the sweep.
// Ports:
//   clk_i         clock, rising edge
//   reset_i       synchronous active-high reset
//   busy_o        high while the clear sweep is in progress
//   clear_addr_o  address to be zeroed this cycle
//   clear_we_o    zero-write strobe for clear_addr_o (never high during reset)
// -----------------------------------------------------------------------------
module bram_init_sequencer
    import bram_pkg::*;
#(
    parameter int unsigned p_ADDRESS_WIDTH = 4,
    parameter int unsigned p_INIT_ON_RESET = 1
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       busy_o,
    output logic [p_ADDRESS_WIDTH-1:0] clear_addr_o,
    output logic                       clear_we_o
);

    init_state_e                state_q, state_d;
    logic [p_ADDRESS_WIDTH-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= (p_INIT_ON_RESET != 0) ? INIT_CLEAR : INIT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clear_we_o = 1'b0;
        case (state_q)
            INIT_CLEAR: begin
                // The reset branch of the register block overrides cnt/state,
                // so only the write strobe needs reset gating here.
                clear_we_o = !reset_i;
                if (cnt_q == '1) begin
                    state_d = INIT_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = INIT_IDLE;
            end
        endcase
    end

    assign busy_o       = (p_INIT_ON_RESET != 0) && (state_q == INIT_CLEAR);
    assign clear_addr_o = cnt_q;

endmodule

// File: rtl/simple_dual_port_bram.sv
// -----------------------------------------------------------------------------
// simple_dual_port_bram
// One write port and one read port on a shared clock. Byte-masked writes,
// selectable same-address read-during-write result, read latency of 1 or 2
// cycles with a read-valid flag, and an optional post-reset clear sweep.
// Ports:
//   i_CLK            clock, rising edge
//   i_RESET          synchronous active-high reset (RAM contents untouched)
//   i_WRITE_ENABLE   write request
//   i_BYTE_ENABLE    per-lane write mask, bit k covers data [8k+7:8k]
//   i_WRITE_ADDRESS  write address
//   i_WRITE_DATA     write data
//   i_READ_ENABLE    read request
//   i_READ_ADDRESS   read address
//   o_READ_DATA      registered read data, 0 when no read result is present
//   o_READ_VALID     high when o_READ_DATA holds an accepted read's result
//   o_INIT_BUSY      high during the clear sweep; requests ignored meanwhile
// -----------------------------------------------------------------------------
module simple_dual_port_bram
    import bram_pkg::*;
#(
    parameter int unsigned p_ADDRESS_WIDTH = 4,
    parameter int unsigned p_DATA_WIDTH    = 16,
    parameter int unsigned p_READ_LATENCY  = 1,
    parameter int unsigned p_RDW_MODE      = 0,
    parameter int unsigned p_INIT_ON_RESET = 1
) (
    input  logic                                     i_CLK,
    input  logic                                     i_RESET,
    input  logic                                     i_WRITE_ENABLE,
    input  logic [byte_lanes(p_DATA_WIDTH)-1:0]      i_BYTE_ENABLE,
    input  logic [p_ADDRESS_WIDTH-1:0]               i_WRITE_ADDRESS,
    input  logic [p_DATA_WIDTH-1:0]                  i_WRITE_DATA,
    input  logic                                     i_READ_ENABLE,
    input  logic [p_ADDRESS_WIDTH-1:0]               i_READ_ADDRESS,
    output logic [p_DATA_WIDTH-1:0]                  o_READ_DATA,
    output logic                                     o_READ_VALID,
    output logic                                     o_INIT_BUSY
);

    localparam int unsigned DEPTH = 2 ** p_ADDRESS_WIDTH;

    logic [p_DATA_WIDTH-1:0]    mem_q [DEPTH];

    logic                       init_busy;
    logic [p_ADDRESS_WIDTH-1:0] clear_addr;
    logic                       clear_we;

    logic                       wr_ok;
    logic                       rd_ok;
    logic                       bypass;
    logic [p_DATA_WIDTH-1:0]    wr_word;
    logic [p_DATA_WIDTH-1:0]    rd_word;

    logic [p_DATA_WIDTH-1:0]    rd1_data_q;
    logic                       rd1_valid_q;

    bram_init_sequencer #(
        .p_ADDRESS_WIDTH (p_ADDRESS_WIDTH),
        .p_INIT_ON_RESET (p_INIT_ON_RESET)
    ) u_init (
        .clk_i        (i_CLK),
        .reset_i      (i_RESET),
        .busy_o       (init_busy),
        .clear_addr_o (clear_addr),
        .clear_we_o   (clear_we)
    );

    assign wr_ok = i_WRITE_ENABLE && !init_busy && !i_RESET;
    assign rd_ok = i_READ_ENABLE && !init_busy;

    assign wr_word = p_DATA_WIDTH'(merge_bytes(MAX_DATA_WIDTH'(mem_q[i_WRITE_ADDRESS]),
                                               MAX_DATA_WIDTH'(i_WRITE_DATA),
                                               MAX_LANES'(i_BYTE_ENABLE)));

    // Write-first forwards the merged word, so unmasked lanes still read old data.
    assign bypass  = (p_RDW_MODE == RDW_WRITE_FIRST) && wr_ok &&
                     (i_WRITE_ADDRESS == i_READ_ADDRESS);
    assign rd_word = bypass ? wr_word : mem_q[i_READ_ADDRESS];

    // Storage has no reset; the sequencer's strobe is already reset-gated.
    always_ff @(posedge i_CLK) begin
        if (clear_we) begin
            mem_q[clear_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[i_WRITE_ADDRESS] <= wr_word;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            rd1_data_q  <= '0;
            rd1_valid_q <= 1'b0;
        end else if (rd_ok) begin
            rd1_data_q  <= rd_word;
            rd1_valid_q <= 1'b1;
        end else begin
            rd1_data_q  <= '0;
            rd1_valid_q <= 1'b0;
        end
    end

    if (p_READ_LATENCY == 2) begin : g_lat2
        logic [p_DATA_WIDTH-1:0] rd2_data_q;
        logic                    rd2_valid_q;

        always_ff @(posedge i_CLK) begin
            if (i_RESET) begin
                rd2_data_q  <= '0;
                rd2_valid_q <= 1'b0;
            end else begin
                rd2_data_q  <= rd1_valid_q ? rd1_data_q : '0;
                rd2_valid_q <= rd1_valid_q;
            end
        end

        assign o_READ_DATA  = rd2_data_q;
        assign o_READ_VALID = rd2_valid_q;
    end else begin : g_lat1
        assign o_READ_DATA  = rd1_data_q;
        assign o_READ_VALID = rd1_valid_q;
    end

    assign o_INIT_BUSY = init_busy;

endmodule

// File: doc/simple_dual_port_bram.md
Name: simple_dual_port_bram

Overview:
Parametrised successor to the single-port block RAM: one write port and one read port sharing one clock. Adds per-byte write enables, a selectable read-during-write mode, and an optional second output register stage with a read-valid flag. An optional post-reset clear sequencer zeroes every word before the RAM accepts traffic. Used as the storage core under FIFOs, line buffers and register files.

Parameters:
p_ADDRESS_WIDTH, 4, address bits; depth = 2**p_ADDRESS_WIDTH words
p_DATA_WIDTH, 16, word width; must be a multiple of 8; byte lanes L = p_DATA_WIDTH/8
p_READ_LATENCY, 1, read latency in cycles; legal values 1 or 2
p_RDW_MODE, 0, same-address read-during-write result; 0 = read-first (old data), 1 = write-first (new merged data)
p_INIT_ON_RESET, 1, 1 = zero the whole array after reset; 0 = no clear, contents unaffected by reset

Ports:
i_CLK  in  1  clock; all logic on the rising edge
i_RESET  in  1  synchronous, active-high reset
i_WRITE_ENABLE  in  1  write request
i_BYTE_ENABLE  in  L  per-lane write mask; bit k covers data bits [8k+7:8k]
i_WRITE_ADDRESS  in  p_ADDRESS_WIDTH  write address
i_WRITE_DATA  in  p_DATA_WIDTH  write data
i_READ_ENABLE  in  1  read request
i_READ_ADDRESS  in  p_ADDRESS_WIDTH  read address
o_READ_DATA  out  p_DATA_WIDTH  registered read data
o_READ_VALID  out  1  high in the cycle o_READ_DATA holds the result of an accepted read
o_INIT_BUSY  out  1  high while the clear sequence runs; all requests are ignored while high

Behaviour:
- Reset, sampled on the rising edge:
  - o_READ_DATA=0, o_READ_VALID=0, all pipeline stages cleared.
  - o_INIT_BUSY = p_INIT_ON_RESET.
  - RAM contents are not changed while i_RESET is high.
- Clear sequencer (bram_init_sequencer) states:
  - IDLE -> CLEAR when i_RESET=1 and p_INIT_ON_RESET=1. The counter is held at 0 while i_RESET stays high.
  - In CLEAR, each cycle with i_RESET=0 writes 0 to address = counter and then increments the counter.
  - When the counter reaches 2**p_ADDRESS_WIDTH-1, that cycle writes the last word, the FSM returns to IDLE and o_INIT_BUSY falls at that edge.
  - The clear therefore takes exactly 2**p_ADDRESS_WIDTH cycles after reset deasserts.
  - Reset asserted mid-clear restarts the sequence at address 0.
  - With p_INIT_ON_RESET=0 the FSM stays in IDLE and o_INIT_BUSY is constant 0.
- While o_INIT_BUSY=1, i_WRITE_ENABLE and i_READ_ENABLE are ignored: no user write, o_READ_VALID=0, o_READ_DATA=0.
- Write:
  - When i_WRITE_ENABLE=1, each lane with i_BYTE_ENABLE[k]=1 takes i_WRITE_DATA in that lane; lanes with 0 are unchanged.
  - An all-zero mask is a no-op.
  - The written data is visible to a read issued in the next cycle.
- Read, accepted when i_READ_ENABLE=1 and the block is not busy:
  - Latency 1: at the next edge o_READ_DATA = mem[i_READ_ADDRESS] and o_READ_VALID=1.
  - A cycle with no accepted read gives o_READ_DATA=0 and o_READ_VALID=0 at the next edge.
  - Latency 2: stage-1 data and valid are registered again; o_READ_DATA and o_READ_VALID appear 2 edges after the request. Stage 2 carries 0 whenever stage 1 is invalid.
  - Back-to-back reads are accepted every cycle at both latencies.
- Read and write to the same address in the same cycle:
  - p_RDW_MODE=0: the read returns the pre-write word.
  - p_RDW_MODE=1: the read returns the merged word, i.e. enabled lanes from i_WRITE_DATA and the other lanes from the old word.
  - Different addresses never interact.
- Widths and addressing: addresses are exactly p_ADDRESS_WIDTH bits wide, so every address is in range and there is no wrap or overflow.

Decomposition:
- Shared package bram_pkg holds:
  - constants RDW_READ_FIRST=0 and RDW_WRITE_FIRST=1;
  - function byte_lanes(data_width) = data_width/8;
  - a function merge_bytes(old, new, mask) used by both the write path and the write-first bypass.
- One sub-module, bram_init_sequencer: IDLE/CLEAR FSM plus address counter. Outputs busy, clear_addr and clear_we.

Test Plan:
1. Default parameters with p_INIT_ON_RESET=1. Hold reset 3 cycles, release -> o_INIT_BUSY stays high exactly 16 cycles. Reading all addresses afterwards returns 0x0000 with o_READ_VALID=1.
2. Write 0xBEEF to address 3 with mask 2'b11, then write 0x1200 with mask 2'b10; read address 3 -> 0x12EF one cycle after the request.
3. Same-cycle write 0xAAAA (mask 11) and read of address 5, which holds 0x5555. With p_RDW_MODE=0 -> 0x5555; with p_RDW_MODE=1 -> 0xAAAA.
4. p_READ_LATENCY=2, reads to addresses 0,1,2 on consecutive cycles holding 0x10,0x11,0x12 -> data appears 2 cycles after each request, valid high for 3 consecutive cycles, then 0 with valid=0.
5. Assert reset at clear address 7 -> busy stays high and the sequence restarts from address 0, taking a further 16 cycles. User writes during busy leave the RAM at zero.
6. While idle, drive a write with i_BYTE_ENABLE=2'b00 to address 9 holding 0x1234 -> a later read of address 9 returns 0x1234.
